// File: rtl/borrow_lookahead_subtractor_pipe.sv
// Pipelined WIDTH-bit subtractor: diff = a - b - borrow_in, one GROUP-bit
// borrow look-ahead slice resolved per stage, valid/ready stream in and out.
module borrow_lookahead_subtractor_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int unsigned STAGES = WIDTH / GROUP;
   localparam int unsigned MSB    = WIDTH - 1;

   // One slice: every borrow is a flat sum-of-products of g/p and the slice
   // borrow-in, so no borrow depends on another borrow inside the slice.
   // Returns {borrow_out, diff_bits}.
   function automatic logic [GROUP:0] slice_sub(input logic [GROUP-1:0] x,
                                                input logic [GROUP-1:0] y,
                                                input logic             bw0);
      logic [GROUP-1:0] g;
      logic [GROUP-1:0] p;
      logic [GROUP:0]   bw;
      logic             term;
      g     = ~x & y;
      p     = ~(x ^ y);
      bw    = '0;
      bw[0] = bw0;
      for (int unsigned i = 1; i <= GROUP; i++) begin
         term = bw0;
         for (int unsigned m = 0; m < i; m++) term = term & p[m];
         bw[i] = term;
         for (int unsigned j = 0; j < i; j++) begin
            term = g[j];
            for (int unsigned m = j + 1; m < i; m++) term = term & p[m];
            bw[i] = bw[i] | term;
         end
      end
      return {bw[GROUP], x ^ y ^ bw[GROUP-1:0]};
   endfunction

   logic advance;

   // Stage registers
   logic             valid_q [STAGES];
   logic [WIDTH-1:0] diff_q  [STAGES];
   logic             bw_q    [STAGES];
   logic [WIDTH-1:0] opa_q   [STAGES];
   logic [WIDTH-1:0] opb_q   [STAGES];
   logic             sa_q    [STAGES];
   logic             sb_q    [STAGES];
   logic             ovf_q;

   // Per-stage inputs (previous stage or the operand port) and results
   logic             src_valid [STAGES];
   logic [WIDTH-1:0] src_diff  [STAGES];
   logic             src_bw    [STAGES];
   logic [WIDTH-1:0] src_a     [STAGES];
   logic [WIDTH-1:0] src_b     [STAGES];
   logic             src_sa    [STAGES];
   logic             src_sb    [STAGES];
   logic [GROUP:0]   slice_res [STAGES];
   logic [WIDTH-1:0] nxt_diff  [STAGES];
   logic             nxt_bw    [STAGES];
   logic             nxt_ovf;

   assign out_valid  = valid_q[STAGES-1];
   assign diff       = diff_q[STAGES-1];
   assign borrow_out = bw_q[STAGES-1];
   assign overflow   = ovf_q;
   assign advance    = out_ready | ~out_valid;
   assign in_ready   = advance & ~rst;

   // Select what each stage consumes: stage 0 takes the port, others the prior stage
   always_comb begin
      src_valid[0] = in_valid & in_ready;
      src_diff[0]  = '0;
      src_bw[0]    = borrow_in;
      src_a[0]     = a;
      src_b[0]     = b;
      src_sa[0]    = a[MSB];
      src_sb[0]    = b[MSB];
      for (int unsigned k = 1; k < STAGES; k++) begin
         src_valid[k] = valid_q[k-1];
         src_diff[k]  = diff_q[k-1];
         src_bw[k]    = bw_q[k-1];
         src_a[k]     = opa_q[k-1];
         src_b[k]     = opb_q[k-1];
         src_sa[k]    = sa_q[k-1];
         src_sb[k]    = sb_q[k-1];
      end
   end

   // Resolve slice k in stage k; overflow is formed alongside the MSB slice
   always_comb begin
      nxt_ovf = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         slice_res[k] = slice_sub(src_a[k][GROUP-1:0], src_b[k][GROUP-1:0], src_bw[k]);
         nxt_diff[k]  = src_diff[k];
         nxt_diff[k][k*GROUP +: GROUP] = slice_res[k][GROUP-1:0];
         nxt_bw[k]    = slice_res[k][GROUP];
      end
      nxt_ovf = (src_sa[STAGES-1] != src_sb[STAGES-1]) &
                (nxt_diff[STAGES-1][MSB] != src_sa[STAGES-1]);
   end

   // Pipeline shift; data only loads with a valid beat so empty slots keep old values
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            diff_q[k]  <= '0;
            bw_q[k]    <= 1'b0;
            opa_q[k]   <= '0;
            opb_q[k]   <= '0;
            sa_q[k]    <= 1'b0;
            sb_q[k]    <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            valid_q[k] <= src_valid[k];
            if (src_valid[k]) begin
               diff_q[k] <= nxt_diff[k];
               bw_q[k]   <= nxt_bw[k];
               opa_q[k]  <= src_a[k] >> GROUP;
               opb_q[k]  <= src_b[k] >> GROUP;
               sa_q[k]   <= src_sa[k];
               sb_q[k]   <= src_sb[k];
            end
         end
         if (src_valid[STAGES-1]) ovf_q <= nxt_ovf;
      end
   end

endmodule
